fft_frame_arb: RTL and testbench

- Shares the single 16-point FFT engine between two sample sources (ch0, ch1), one whole frame at a time.
- Grants a channel, streams its 16 input samples into the engine, latches that frame's inverse flag, then routes the 16 result samples back with a channel tag.
- Sits between the two front-end sources and the FFT top-level engine; the engine shares this block's clk/reset.

---
 rtl/fft_pkg.sv | 16 +
 rtl/fft_rr_arb2.sv | 19 +
 rtl/fft_frame_arb.sv | 184 ++++++++++++++++++
 tb/tb_fft_frame_arb.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and encodings for the FFT frame arbiter.
package fft_pkg;

    localparam int DATA_W    = 16;
    localparam int FRAME_LEN = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        WAIT_OUT = 2'd2
    } state_e;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

endpackage

// File: rtl/fft_rr_arb2.sv
// Two-request round-robin picker: on contention the channel that was not
// served last wins; a lone requester always wins.
module fft_rr_arb2 (
    input  logic [1:0] req,
    input  logic       rr_last,
    output logic       gnt_valid,
    output logic       gnt_id
);

    // Pick the winner; purely combinational, sampled by the owner FSM.
    always_comb begin
        gnt_valid = |req;
        gnt_id    = req[1];
        if (&req) begin
            gnt_id = ~rr_last;
        end
    end

endmodule

// File: rtl/fft_frame_arb.sv
// fft_frame_arb: shares one 16-point FFT engine between two sample sources,
// one whole frame at a time. A granted channel streams its frame in, the
// frame's direction flag is frozen at grant, and the results are returned
// through a registered output stage tagged with the owning channel.
module fft_frame_arb #(
    parameter int DATA_W    = fft_pkg::DATA_W,
    parameter int FRAME_LEN = fft_pkg::FRAME_LEN,
    parameter int CNT_W     = $clog2(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              reset,
    // channel 0 source
    input  logic              ch0_push,
    input  logic [DATA_W-1:0] ch0_real,
    input  logic [DATA_W-1:0] ch0_imag,
    input  logic              ch0_inv,
    output logic              ch0_stall,
    // channel 1 source
    input  logic              ch1_push,
    input  logic [DATA_W-1:0] ch1_real,
    input  logic [DATA_W-1:0] ch1_imag,
    input  logic              ch1_inv,
    output logic              ch1_stall,
    // engine input side
    output logic              fft_in_push,
    output logic [DATA_W-1:0] fft_in_real,
    output logic [DATA_W-1:0] fft_in_imag,
    input  logic              fft_in_stall,
    output logic              fft_inv,
    // engine output side
    input  logic              fft_out_push,
    input  logic [DATA_W-1:0] fft_out_real,
    input  logic [DATA_W-1:0] fft_out_imag,
    output logic              fft_out_stall,
    // registered result stream
    output logic              out_push_F,
    output logic [DATA_W-1:0] out_real_F,
    output logic [DATA_W-1:0] out_imag_F,
    output logic              out_ch_F,
    output logic              out_last_F,
    input  logic              out_stall,
    // status
    output logic              busy_F,
    output logic              err_F
);

    import fft_pkg::*;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    state_e             state_q,   state_d;
    logic [CNT_W-1:0]   in_cnt_q,  in_cnt_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic               grant_q,   grant_d;
    logic               rr_last_q, rr_last_d;
    logic               inv_lat_q, inv_lat_d;

    logic               gnt_valid;
    logic               gnt_id;
    logic               sel_push;
    logic               out_accept;

    fft_rr_arb2 u_arb (
        .req       ({ch1_push, ch0_push}),
        .rr_last   (rr_last_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // The owner's sample is always presented; fft_in_push qualifies it.
    assign sel_push      = (grant_q == CH1) ? ch1_push : ch0_push;
    assign fft_in_real   = (grant_q == CH1) ? ch1_real : ch0_real;
    assign fft_in_imag   = (grant_q == CH1) ? ch1_imag : ch0_imag;
    assign fft_inv       = inv_lat_q;
    assign fft_out_stall = out_stall;

    // Next-state, counters and handshake muxing for the frame owner FSM.
    // NOTE: every output of this block gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        grant_d     = grant_q;
        rr_last_d   = rr_last_q;
        inv_lat_d   = inv_lat_q;
        ch0_stall   = 1'b1;
        ch1_stall   = 1'b1;
        fft_in_push = 1'b0;
        out_accept  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Grant cycle: nothing is accepted, only ownership and the
                // direction flag are captured.
                if (gnt_valid) begin
                    grant_d   = gnt_id;
                    inv_lat_d = (gnt_id == CH1) ? ch1_inv : ch0_inv;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                fft_in_push = sel_push;
                if (grant_q == CH1) begin
                    ch1_stall = fft_in_stall;
                end else begin
                    ch0_stall = fft_in_stall;
                end
                if (sel_push && !fft_in_stall) begin
                    if (in_cnt_q == LAST_IDX) begin
                        in_cnt_d = '0;
                        state_d  = WAIT_OUT;
                    end else begin
                        in_cnt_d = in_cnt_q + 1'b1;
                    end
                end
            end
            WAIT_OUT: begin
                // A result moves only when downstream is not stalling it.
                out_accept = fft_out_push && !out_stall;
                if (out_accept) begin
                    if (out_cnt_q == LAST_IDX) begin
                        out_cnt_d = '0;
                        rr_last_d = grant_q;
                        state_d   = IDLE;
                    end else begin
                        out_cnt_d = out_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            grant_q   <= CH0;
            rr_last_q <= CH1;
            inv_lat_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            grant_q   <= grant_d;
            rr_last_q <= rr_last_d;
            inv_lat_q <= inv_lat_d;
        end
    end

    // Registered result stage; results outside WAIT_OUT are dropped and
    // flagged in the sticky error bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_push_F <= 1'b0;
            out_real_F <= '0;
            out_imag_F <= '0;
            out_ch_F   <= 1'b0;
            out_last_F <= 1'b0;
            busy_F     <= 1'b0;
            err_F      <= 1'b0;
        end else begin
            out_push_F <= out_accept;
            if (out_accept) begin
                out_real_F <= fft_out_real;
                out_imag_F <= fft_out_imag;
            end
            out_ch_F   <= grant_q;
            out_last_F <= out_accept && (out_cnt_q == LAST_IDX);
            busy_F     <= (state_d != IDLE);
            if (fft_out_push && (state_q != WAIT_OUT)) begin
                err_F <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_arb.sv
// Self-checking bench for fft_frame_arb: directed frames from two sources,
// a bench-side engine, and a frame-level model checked every cycle.
module tb_fft_frame_arb;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ch0_push = 1'b0, ch1_push = 1'b0;
    logic          ch0_inv = 1'b0,  ch1_inv = 1'b0;
    logic [DW-1:0] ch0_real = '0, ch0_imag = '0, ch1_real = '0, ch1_imag = '0;
    logic          ch0_stall, ch1_stall;
    logic          fft_in_push;
    logic [DW-1:0] fft_in_real, fft_in_imag;
    logic          fft_in_stall = 1'b0;
    logic          fft_inv;
    logic          fft_out_push = 1'b0;
    logic [DW-1:0] fft_out_real = '0, fft_out_imag = '0;
    logic          fft_out_stall;
    logic          out_push_F;
    logic [DW-1:0] out_real_F, out_imag_F;
    logic          out_ch_F, out_last_F;
    logic          out_stall = 1'b0;
    logic          busy_F, err_F;

    int n_checks = 0;
    int n_errors = 0;

    // frame-level model state
    int m_owner = -1;
    int m_in    = 0;
    int m_out   = 0;
    bit m_inv   = 1'b0;
    bit m_last  = 1'b1;
    bit m_err   = 1'b0;

    // observation of the result stream and bench engine
    int            n_out = 0;
    int            n_last = 0;
    logic [DW-1:0] first_re = '0, last_re = '0, last_im = '0;
    int            ch_order[$];
    int            inv_bad = 0;
    int            eng_got = 0;

    fft_frame_arb dut (
        .clk           (clk),
        .reset         (reset),
        .ch0_push      (ch0_push),
        .ch0_real      (ch0_real),
        .ch0_imag      (ch0_imag),
        .ch0_inv       (ch0_inv),
        .ch0_stall     (ch0_stall),
        .ch1_push      (ch1_push),
        .ch1_real      (ch1_real),
        .ch1_imag      (ch1_imag),
        .ch1_inv       (ch1_inv),
        .ch1_stall     (ch1_stall),
        .fft_in_push   (fft_in_push),
        .fft_in_real   (fft_in_real),
        .fft_in_imag   (fft_in_imag),
        .fft_in_stall  (fft_in_stall),
        .fft_inv       (fft_inv),
        .fft_out_push  (fft_out_push),
        .fft_out_real  (fft_out_real),
        .fft_out_imag  (fft_out_imag),
        .fft_out_stall (fft_out_stall),
        .out_push_F    (out_push_F),
        .out_real_F    (out_real_F),
        .out_imag_F    (out_imag_F),
        .out_ch_F      (out_ch_F),
        .out_last_F    (out_last_F),
        .out_stall     (out_stall),
        .busy_F        (busy_F),
        .err_F         (err_F)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic clear_mon();
        n_out = 0;
        n_last = 0;
        ch_order.delete();
        inv_bad = 0;
        eng_got = 0;
    endtask

    task automatic idle_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // One source: n samples, real = re0+k, imag = im0+k*im_step.
    task automatic src_frame(input bit ch, input int n, input logic [DW-1:0] re0,
                             input logic [DW-1:0] im0, input int im_step,
                             input bit inv, input int flip_at);
        bit xfer;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (ch) begin
                ch1_push = 1'b1;
                ch1_real = re0 + 16'(k);
                ch1_imag = im0 + 16'(k * im_step);
                if (k == 0) ch1_inv = inv;
                else if (k == flip_at) ch1_inv = ~ch1_inv;
            end else begin
                ch0_push = 1'b1;
                ch0_real = re0 + 16'(k);
                ch0_imag = im0 + 16'(k * im_step);
                if (k == 0) ch0_inv = inv;
                else if (k == flip_at) ch0_inv = ~ch0_inv;
            end
            xfer = 1'b0;
            while (!xfer) begin
                #4;
                xfer = ch ? !ch1_stall : !ch0_stall;
                @(posedge clk);
                if (!xfer) @(negedge clk);
            end
        end
        @(negedge clk);
        if (ch) ch1_push = 1'b0;
        else    ch0_push = 1'b0;
    endtask

    // Bench engine: collects n_in samples (one-cycle stall on samples
    // is_lo..is_hi), then returns result j = {re+0x1000, im^0x00FF} with a
    // one-cycle downstream stall on results os_lo..os_hi.
    task automatic engine_frame(input int n_in, input int is_lo, input int is_hi,
                                input int os_lo, input int os_hi,
                                input bit do_out, input bit exp_inv);
        logic [DW-1:0] re [16];
        logic [DW-1:0] im [16];
        int got;
        bit st_done;
        got = 0;
        st_done = 1'b0;
        while (got < n_in) begin
            @(negedge clk);
            fft_in_stall = (got + 1 >= is_lo) && (got + 1 <= is_hi) && !st_done;
            #4;
            if (fft_in_push && !fft_in_stall) begin
                re[got] = fft_in_real;
                im[got] = fft_in_imag;
                if (fft_inv !== exp_inv) inv_bad++;
                got++;
                st_done = 1'b0;
            end else if (fft_in_stall) begin
                st_done = 1'b1;
            end
        end
        eng_got = got;
        if (do_out) begin
            for (int j = 0; j < 16; j++) begin
                st_done = 1'b0;
                do begin
                    @(negedge clk);
                    fft_out_push = 1'b1;
                    fft_out_real = re[j] + 16'h1000;
                    fft_out_imag = im[j] ^ 16'h00FF;
                    out_stall    = (j + 1 >= os_lo) && (j + 1 <= os_hi) && !st_done;
                    st_done      = out_stall;
                    if (fft_inv !== exp_inv) inv_bad++;
                    @(posedge clk);
                end while (out_stall);
            end
            @(negedge clk);
            fft_out_push = 1'b0;
            out_stall    = 1'b0;
        end
    endtask

    // Compare process: pre-edge combinational checks and model update,
    // then post-edge registered-output checks, every cycle.
    initial begin : cmp
        bit            e_push, e_last, e_busy, e_ch;
        logic [DW-1:0] e_re, e_im;
        bit            idle, load, wt, fip, pick;
        e_re = '0;
        e_im = '0;
        forever begin
            @(negedge clk);
            #4;
            e_push = 1'b0;
            e_last = 1'b0;
            e_ch   = 1'b0;
            if (!reset) begin
                m_owner = -1; m_in = 0; m_out = 0;
                m_inv = 1'b0; m_last = 1'b1; m_err = 1'b0;
                e_busy = 1'b0;
                check("rst_ch0_stall", ch0_stall, 1);
                check("rst_ch1_stall", ch1_stall, 1);
                check("rst_fft_in_push", fft_in_push, 0);
                check("rst_fft_inv", fft_inv, 0);
            end else begin
                idle = (m_owner < 0);
                load = !idle && (m_in < 16);
                wt   = !idle && (m_in == 16);
                check("ch0_stall", ch0_stall, (load && m_owner == 0) ? fft_in_stall : 1'b1);
                check("ch1_stall", ch1_stall, (load && m_owner == 1) ? fft_in_stall : 1'b1);
                fip = load && ((m_owner == 1) ? ch1_push : ch0_push);
                check("fft_in_push", fft_in_push, fip);
                if (fip) begin
                    check("fft_in_real", fft_in_real, (m_owner == 1) ? ch1_real : ch0_real);
                    check("fft_in_imag", fft_in_imag, (m_owner == 1) ? ch1_imag : ch0_imag);
                end
                check("fft_inv", fft_inv, m_inv);
                check("fft_out_stall", fft_out_stall, out_stall);

                if (fft_out_push) begin
                    if (wt) begin
                        if (!out_stall) begin
                            e_push = 1'b1;
                            e_re   = fft_out_real;
                            e_im   = fft_out_imag;
                            e_ch   = (m_owner == 1);
                            e_last = (m_out == 15);
                            m_out++;
                        end
                    end else begin
                        m_err = 1'b1;
                    end
                end
                if (idle) begin
                    if (ch0_push || ch1_push) begin
                        pick    = (ch0_push && ch1_push) ? !m_last : ch1_push;
                        m_owner = int'(pick);
                        m_inv   = pick ? ch1_inv : ch0_inv;
                    end
                end else if (load) begin
                    if (fip && !fft_in_stall) m_in++;
                end else if (m_out == 16) begin
                    m_last  = (m_owner == 1);
                    m_owner = -1;
                    m_in    = 0;
                    m_out   = 0;
                end
                e_busy = (m_owner >= 0);
            end

            @(posedge clk);
            #1;
            if (!reset) begin
                check("rst_out_push_F", out_push_F, 0);
                check("rst_out_real_F", out_real_F, 0);
                check("rst_out_imag_F", out_imag_F, 0);
                check("rst_out_ch_F", out_ch_F, 0);
                check("rst_out_last_F", out_last_F, 0);
                check("rst_busy_F", busy_F, 0);
                check("rst_err_F", err_F, 0);
            end else begin
                check("out_push_F", out_push_F, e_push);
                if (e_push) begin
                    check("out_real_F", out_real_F, e_re);
                    check("out_imag_F", out_imag_F, e_im);
                    check("out_ch_F", out_ch_F, e_ch);
                    check("out_last_F", out_last_F, e_last);
                end
                check("busy_F", busy_F, e_busy);
                check("err_F", err_F, m_err);
                if (out_push_F) begin
                    if (n_out == 0) first_re = out_real_F;
                    n_out++;
                    last_re = out_real_F;
                    last_im = out_imag_F;
                    if (out_last_F) begin
                        n_last++;
                        ch_order.push_back(int'(out_ch_F));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin : main
        int exp_ord[4];
        exp_ord = '{0, 1, 0, 1};
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Single forward frame on ch0: real 1..16, imag 0.
        clear_mon();
        fork
            src_frame(1'b0, 16, 16'd1, 16'd0, 0, 1'b0, -1);
            engine_frame(16, 0, 0, 0, 0, 1'b1, 1'b0);
        join
        idle_wait(4);
        check("t1_n_out", n_out, 16);
        check("t1_n_last", n_last, 1);
        check("t1_first_re", first_re, 16'h1001);
        check("t1_last_re", last_re, 16'h1010);
        check("t1_last_im", last_im, 16'h00FF);
        check("t1_busy_low", busy_F, 0);
        check("t1_inv_bad", inv_bad, 0);

        // Contention from reset: ch0, ch1, ch0, ch1.
        do_reset();
        clear_mon();
        fork
            begin
                src_frame(1'b0, 16, 16'h0100, 16'h0010, 1, 1'b0, -1);
                src_frame(1'b0, 16, 16'h0300, 16'h0030, 1, 1'b0, -1);
            end
            begin
                src_frame(1'b1, 16, 16'h0200, 16'h0020, 1, 1'b0, -1);
                src_frame(1'b1, 16, 16'h0400, 16'h0040, 1, 1'b0, -1);
            end
            begin
                for (int f = 0; f < 4; f++) engine_frame(16, 0, 0, 0, 0, 1'b1, 1'b0);
            end
        join
        idle_wait(4);
        check("t2_n_out", n_out, 64);
        check("t2_n_last", n_last, 4);
        for (int i = 0; i < ch_order.size() && i < 4; i++) begin
            check($sformatf("t2_order%0d", i), ch_order[i], exp_ord[i]);
        end
        check("t2_last_re", last_re, 16'h140F);

        // Inverse lock: ch1 inv=1 with ch1_inv toggling mid-frame, then ch0 forward.
        clear_mon();
        fork
            src_frame(1'b1, 16, 16'h0500, 16'h0000, 1, 1'b1, 5);
            engine_frame(16, 0, 0, 0, 0, 1'b1, 1'b1);
        join
        idle_wait(2);
        check("t3_inv_held", fft_inv, 1);
        check("t3_inv_bad_ch1", inv_bad, 0);
        fork
            src_frame(1'b0, 16, 16'h0600, 16'h0000, 1, 1'b0, -1);
            engine_frame(16, 0, 0, 0, 0, 1'b1, 1'b0);
        join
        idle_wait(2);
        check("t3_inv_fwd", fft_inv, 0);
        check("t3_inv_bad_all", inv_bad, 0);
        check("t3_n_last", n_last, 2);

        // Stalls: engine input on samples 3-5, downstream on results 8-10.
        clear_mon();
        fork
            src_frame(1'b0, 16, 16'h0700, 16'h0020, 2, 1'b0, -1);
            engine_frame(16, 3, 5, 8, 10, 1'b1, 1'b0);
        join
        idle_wait(4);
        check("t4_eng_got", eng_got, 16);
        check("t4_n_out", n_out, 16);
        check("t4_first_re", first_re, 16'h1700);
        check("t4_last_re", last_re, 16'h170F);
        check("t4_last_im", last_im, 16'h00C1);

        // Spurious result in IDLE: dropped, sticky error until reset.
        clear_mon();
        @(negedge clk);
        fft_out_push = 1'b1;
        fft_out_real = 16'hDEAD;
        fft_out_imag = 16'hBEEF;
        @(negedge clk);
        fft_out_push = 1'b0;
        idle_wait(3);
        check("t5_err_set", err_F, 1);
        check("t5_no_out", n_out, 0);
        idle_wait(5);
        check("t5_err_sticky", err_F, 1);
        do_reset();
        check("t5_err_clr", err_F, 0);

        // Reset in the middle of LOAD after 7 samples, then a clean frame.
        clear_mon();
        fork
            src_frame(1'b0, 7, 16'h0800, 16'h0000, 1, 1'b0, -1);
            engine_frame(7, 0, 0, 0, 0, 1'b0, 1'b0);
        join
        check("t6_got7", eng_got, 7);
        check("t6_busy_mid", busy_F, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t6_rst_busy", busy_F, 0);
        check("t6_rst_stall", ch0_stall, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        clear_mon();
        fork
            src_frame(1'b0, 16, 16'h0900, 16'h0000, 1, 1'b0, -1);
            engine_frame(16, 0, 0, 0, 0, 1'b1, 1'b0);
        join
        idle_wait(4);
        check("t6_n_out", n_out, 16);
        check("t6_first_re", first_re, 16'h1900);
        check("t6_last_re", last_re, 16'h190F);
        check("t6_n_last", n_last, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
